// File: rtl/pc_fetch_ctrl_if.sv
// pc_fetch_ctrl_if: redirect, instruction-memory and fetch-buffer signals.
// align_err exists only when PC_ALIGN_CHECK_EN is defined.
interface pc_fetch_ctrl_if #(
  parameter int IW = 16
);
  logic          br_take;
  logic [7:0]    br_target;
  logic          imem_req;
  logic [7:0]    imem_addr;
  logic          imem_ack;
  logic [IW-1:0] imem_data;
  logic          instr_valid;
  logic          instr_ready;
  logic [IW-1:0] instr;
  logic [7:0]    instr_pc;
  logic          halted;
`ifdef PC_ALIGN_CHECK_EN
  logic          align_err;

  modport master (
    input  br_take,
    input  br_target,
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_data,
    output instr_valid,
    input  instr_ready,
    output instr,
    output instr_pc,
    output halted,
    output align_err
  );

  modport slave (
    output br_take,
    output br_target,
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_data,
    input  instr_valid,
    output instr_ready,
    input  instr,
    input  instr_pc,
    input  halted,
    input  align_err
  );
`else
  modport master (
    input  br_take,
    input  br_target,
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_data,
    output instr_valid,
    input  instr_ready,
    output instr,
    output instr_pc,
    output halted
  );

  modport slave (
    output br_take,
    output br_target,
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_data,
    input  instr_valid,
    output instr_ready,
    input  instr,
    input  instr_pc,
    input  halted
  );
`endif
endinterface

// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: PC register, fetch sequencer and one-entry instruction buffer.
// Optional PC_ALIGN_CHECK_EN rejects misaligned redirects and flags align_err.
module pc_fetch_ctrl #(
  parameter logic [7:0] RESET_PC  = 8'h00,
  parameter int         IW        = 16,
  parameter bit         WRAP_HALT = 1'b1
) (
  input logic             clk,
  input logic             rst,
  pc_fetch_ctrl_if.master bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    BLOCK = 2'd2,
    HALT  = 2'd3
  } state_t;

  state_t        state;
  state_t        state_n;
  logic [7:0]    pc;
  logic [7:0]    pc_n;
  logic [7:0]    pc_sum;
  logic          pc_co;
  logic          valid_q;
  logic [IW-1:0] instr_q;
  logic [7:0]    ipc_q;
  logic          can_load;
  logic          drain;
  logic          req;
  logic          ack_ok;
  logic          br_bad;
  logic          br_hit;
  logic          wrap;
  logic [7:0]    br_addr;

  // Constant +4 incrementer with carry-in tied low.
  function automatic logic [8:0] add4(
    input logic [7:0] a,
    input logic       ci
  );
    return {1'b0, a} + 9'd4 + {8'd0, ci};
  endfunction

  assign {pc_co, pc_sum} = add4(pc, 1'b0);

  assign drain    = valid_q && bus.instr_ready;
  assign can_load = !valid_q || bus.instr_ready;

`ifdef PC_ALIGN_CHECK_EN
  assign br_bad  = bus.br_target[1:0] != 2'b00;
  assign br_addr = bus.br_target;
`else
  assign br_bad  = 1'b0;
  assign br_addr = {bus.br_target[7:2], 2'b00};
`endif

  assign br_hit = bus.br_take && !br_bad
               && (state != HALT);

  // Request only while the buffer can take the word.
  assign req    = (state == REQ) && can_load;
  assign ack_ok = req && bus.imem_ack && !br_hit;
  assign wrap   = ack_ok && pc_co;

  always_comb begin
    state_n = state;
    pc_n    = pc;
    unique case (state)
      IDLE: state_n = REQ;
      REQ: begin
        if (!can_load)
          state_n = BLOCK;
        else if (wrap && WRAP_HALT)
          state_n = HALT;
      end
      BLOCK: begin
        if (can_load)
          state_n = REQ;
      end
      HALT: state_n = HALT;
      default: state_n = IDLE;
    endcase
    if (ack_ok)
      pc_n = pc_sum;
    if (br_hit) begin
      pc_n    = br_addr;
      state_n = (state == REQ) ? IDLE : REQ;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      pc    <= RESET_PC;
    end else begin
      state <= state_n;
      pc    <= pc_n;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      instr_q <= '0;
      ipc_q   <= 8'h00;
    end else if (br_hit) begin
      valid_q <= 1'b0;
    end else if (ack_ok) begin
      valid_q <= 1'b1;
      instr_q <= bus.imem_data;
      ipc_q   <= pc;
    end else if (drain) begin
      valid_q <= 1'b0;
    end
  end

`ifdef PC_ALIGN_CHECK_EN
  logic align_q;

  always_ff @(posedge clk) begin
    if (rst)
      align_q <= 1'b0;
    else if (bus.br_take && br_bad && state != HALT)
      align_q <= 1'b1;
  end

  assign bus.align_err = align_q;
`endif

  assign bus.imem_req    = req;
  assign bus.imem_addr   = pc;
  assign bus.instr_valid = valid_q;
  assign bus.instr       = instr_q;
  assign bus.instr_pc    = ipc_q;
  assign bus.halted      = (state == HALT);

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// tb_pc_fetch_ctrl: directed vectors for pc_fetch_ctrl.
// Two instances share stimulus: WRAP_HALT=1 and WRAP_HALT=0.
module tb_pc_fetch_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ack_en = 1'b0;
  int   ack_dly = 0;
  logic [3:0] wcnt = 4'd0;
  logic [3:0] wcnt_w = 4'd0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  pc_fetch_ctrl_if #(.IW(16)) bus ();
  pc_fetch_ctrl_if #(.IW(16)) bus_w ();

  pc_fetch_ctrl #(
    .RESET_PC (8'h00),
    .IW       (16),
    .WRAP_HALT(1'b1)
  ) dut_h (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  pc_fetch_ctrl #(
    .RESET_PC (8'h00),
    .IW       (16),
    .WRAP_HALT(1'b0)
  ) dut_w (
    .clk(clk),
    .rst(rst),
    .bus(bus_w)
  );

  function automatic logic [15:0] mem(input logic [7:0] a);
    return {a ^ 8'h5A, a};
  endfunction

  // Memory model: ack after ack_dly wait cycles (0 = ack held high).
  always @(posedge clk) begin
    if (!bus.imem_req || bus.imem_ack) wcnt <= 4'd0;
    else if (wcnt != 4'hF) wcnt <= wcnt + 4'd1;
    if (!bus_w.imem_req || bus_w.imem_ack) wcnt_w <= 4'd0;
    else if (wcnt_w != 4'hF) wcnt_w <= wcnt_w + 4'd1;
  end

  assign bus.imem_data   = mem(bus.imem_addr);
  assign bus.imem_ack    = ack_en && (ack_dly == 0
                        || (bus.imem_req && int'(wcnt) >= ack_dly));
  assign bus_w.imem_data = mem(bus_w.imem_addr);
  assign bus_w.imem_ack  = ack_en && (ack_dly == 0
                        || (bus_w.imem_req && int'(wcnt_w) >= ack_dly));
  assign bus_w.br_take     = bus.br_take;
  assign bus_w.br_target   = bus.br_target;
  assign bus_w.instr_ready = bus.instr_ready;

  typedef struct packed {
    logic       rst;
    logic       br;
    logic       rdy;
    logic [7:0] tgt;
    logic       req;
    logic       valid;
    logic       halted;
    logic [7:0] addr;
    logic [7:0] ipc;
  } vec_t;

  localparam int NV = 20;
  vec_t vt [NV];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.br_take = 1'b0;
    bus.br_target = 8'h00;
    bus.instr_ready = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    bus.br_take = 1'b0;
    bus.br_target = 8'h00;
    bus.instr_ready = 1'b1;

    //          rst br rdy tgt    req val hlt addr   ipc
    vt[0]  = '{1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00};
    vt[1]  = '{1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00};
    vt[2]  = '{1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00};
    vt[3]  = '{1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 8'h04, 8'h00};
    vt[4]  = '{1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 8'h08, 8'h04};
    vt[5]  = '{1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 8'h0C, 8'h08};
    vt[6]  = '{1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 8'h10, 8'h0C};
    vt[7]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h10, 8'h0C};
    vt[8]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h10, 8'h0C};
    vt[9]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h10, 8'h0C};
    vt[10] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h10, 8'h0C};
    vt[11] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h10, 8'h0C};
    vt[12] = '{1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 8'h10, 8'h0C};
    vt[13] = '{1'b0, 1'b1, 1'b1, 8'h40, 1'b0, 1'b0, 1'b0, 8'h40, 8'h0C};
    vt[14] = '{1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 8'h40, 8'h0C};
    vt[15] = '{1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 8'h44, 8'h40};
    vt[16] = '{1'b0, 1'b1, 1'b1, 8'h80, 1'b0, 1'b0, 1'b0, 8'h80, 8'h40};
    vt[17] = '{1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 8'h80, 8'h40};
    vt[18] = '{1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 8'h84, 8'h80};
`ifdef PC_ALIGN_CHECK_EN
    vt[19] = '{1'b0, 1'b1, 1'b1, 8'h42, 1'b1, 1'b1, 1'b0, 8'h88, 8'h84};
`else
    vt[19] = '{1'b0, 1'b1, 1'b1, 8'h42, 1'b0, 1'b0, 1'b0, 8'h40, 8'h84};
`endif

    ack_en = 1'b1;
    ack_dly = 0;
    for (int i = 0; i < NV; i++) begin
      rst = vt[i].rst;
      bus.br_take = vt[i].br;
      bus.br_target = vt[i].tgt;
      bus.instr_ready = vt[i].rdy;
      step();
      chk($sformatf("v%0d_req", i), 32'(bus.imem_req), 32'(vt[i].req));
      chk($sformatf("v%0d_valid", i), 32'(bus.instr_valid), 32'(vt[i].valid));
      chk($sformatf("v%0d_halted", i), 32'(bus.halted), 32'(vt[i].halted));
      chk($sformatf("v%0d_addr", i), 32'(bus.imem_addr), 32'(vt[i].addr));
      if (vt[i].rst) begin
        chk($sformatf("v%0d_rst_instr", i), 32'(bus.instr), 32'h0);
        chk($sformatf("v%0d_rst_ipc", i), 32'(bus.instr_pc), 32'h0);
      end else if (vt[i].valid) begin
        chk($sformatf("v%0d_ipc", i), 32'(bus.instr_pc), 32'(vt[i].ipc));
        chk($sformatf("v%0d_instr", i), 32'(bus.instr), 32'(mem(vt[i].ipc)));
      end
    end
    bus.br_take = 1'b0;
`ifdef PC_ALIGN_CHECK_EN
    chk("align_err_set", 32'(bus.align_err), 32'h1);
`endif

    // Delayed ack: address held during wait, one valid per ack.
    ack_dly = 3;
    do_reset();
`ifdef PC_ALIGN_CHECK_EN
    chk("align_err_rst", 32'(bus.align_err), 32'h0);
`endif
    step();
    for (int f = 0; f < 4; f++) begin
      for (int c = 0; c < 4; c++) begin
        chk($sformatf("t2_req_%0d_%0d", f, c), 32'(bus.imem_req), 32'h1);
        chk($sformatf("t2_addr_%0d_%0d", f, c), 32'(bus.imem_addr), 32'(f * 4));
        chk($sformatf("t2_valid_%0d_%0d", f, c), 32'(bus.instr_valid),
            32'(c == 0 && f > 0));
        if (c == 0 && f > 0)
          chk($sformatf("t2_ipc_%0d", f), 32'(bus.instr_pc), 32'((f - 1) * 4));
        step();
      end
    end
    chk("t2_last_valid", 32'(bus.instr_valid), 32'h1);
    chk("t2_last_ipc", 32'(bus.instr_pc), 32'h0C);

    // Reset mid-fetch, then an ack while idle must be ignored.
    ack_dly = 0;
    ack_en = 1'b0;
    do_reset();
    step();
    chk("rr_req_before", 32'(bus.imem_req), 32'h1);
    rst = 1'b1;
    ack_en = 1'b1;
    step();
    chk("rr_req_rst", 32'(bus.imem_req), 32'h0);
    rst = 1'b0;
    step();
    chk("rr_late_ack_valid", 32'(bus.instr_valid), 32'h0);
    chk("rr_req_again", 32'(bus.imem_req), 32'h1);
    step();
    chk("rr_fetch_valid", 32'(bus.instr_valid), 32'h1);
    chk("rr_fetch_ipc", 32'(bus.instr_pc), 32'h00);

    // Wrap at FC: halt vs modulo-256 continuation.
    do_reset();
    step();
    bus.br_take = 1'b1;
    bus.br_target = 8'hFC;
    step();
    bus.br_take = 1'b0;
    chk("w_br_addr", 32'(bus.imem_addr), 32'hFC);
    chk("w_br_req", 32'(bus.imem_req), 32'h0);
    step();
    chk("w_req_fc", 32'(bus.imem_req), 32'h1);
    chk("w_addr_fc", 32'(bus.imem_addr), 32'hFC);
    step();
    chk("h_valid", 32'(bus.instr_valid), 32'h1);
    chk("h_ipc", 32'(bus.instr_pc), 32'hFC);
    chk("h_instr", 32'(bus.instr), 32'(mem(8'hFC)));
    chk("h_halted", 32'(bus.halted), 32'h1);
    chk("h_req", 32'(bus.imem_req), 32'h0);
    chk("nw_valid", 32'(bus_w.instr_valid), 32'h1);
    chk("nw_ipc", 32'(bus_w.instr_pc), 32'hFC);
    chk("nw_halted", 32'(bus_w.halted), 32'h0);
    chk("nw_addr", 32'(bus_w.imem_addr), 32'h00);
    chk("nw_req", 32'(bus_w.imem_req), 32'h1);
    step();
    chk("h_drained", 32'(bus.instr_valid), 32'h0);
    chk("h_req_stay", 32'(bus.imem_req), 32'h0);
    chk("nw_ipc_00", 32'(bus_w.instr_pc), 32'h00);
    chk("nw_addr_04", 32'(bus_w.imem_addr), 32'h04);
    bus.br_take = 1'b1;
    bus.br_target = 8'h20;
    step();
    bus.br_take = 1'b0;
    chk("h_br_ignored", 32'(bus.halted), 32'h1);
    step();
    chk("h_req_after_br", 32'(bus.imem_req), 32'h0);
    chk("h_valid_after_br", 32'(bus.instr_valid), 32'h0);
    rst = 1'b1;
    step();
    chk("h_rst_halted", 32'(bus.halted), 32'h0);
    chk("h_rst_addr", 32'(bus.imem_addr), 32'h00);
    rst = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
